// File: rtl/control_unit_irq.sv
// Single-cycle CPU control unit: opcode decode, conditional jumps on Z, and a
// 4-line prioritized, edge-triggered interrupt controller that injects entries.
module control_unit_irq #(
    parameter logic [9:0] VEC_BASE = 10'h3F0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i,
    input  logic       z_i,
    input  logic [3:0] irq_i,
    output logic       s_inc_o,
    output logic       s_stack_o,
    output logic       pushsignal_o,
    output logic       popsignal_o,
    output logic       we3_o,
    output logic       wez_o,
    output logic       we4_o,
    output logic       we_out_o,
    output logic [1:0] s_inm_o,
    output logic [1:0] s_in_o,
    output logic [1:0] s_out_o,
    output logic [2:0] op_alu_o,
    output logic       irq_take_o,
    output logic [9:0] irq_vector_o,
    output logic [3:0] irq_ack_o,
    output logic       ie_o
);

    localparam logic [5:0] OP_RET  = 6'b000001;
    localparam logic [5:0] OP_RETI = 6'b000010;
    localparam logic [5:0] OP_EI   = 6'b000011;

    logic [3:0] irq_prev_q, irq_prev_d;
    logic [3:0] pend_q, pend_d;
    logic       ie_q, ie_d;
    logic       armed_q;
    logic [3:0] rise;
    logic [1:0] sel_idx;
    logic [3:0] sel_oh;
    logic       take;

    // Lowest-index pending line wins.
    always_comb begin
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = i[1:0];
        end
        sel_oh = 4'b0001 << sel_idx;
    end

    assign take = rst_ni & ie_q & (|pend_q);

    // armed_q masks the first cycle after reset so lines already high are not edges.
    assign rise       = irq_i & ~irq_prev_q & {4{armed_q}};
    assign irq_prev_d = irq_i;

    always_comb begin
        pend_d = (pend_q & ~(take ? sel_oh : 4'b0000)) | rise;
        if (take)
            ie_d = 1'b0;
        else if (opcode_i == OP_EI || opcode_i == OP_RETI)
            ie_d = 1'b1;
        else
            ie_d = ie_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_prev_q <= 4'b0000;
            pend_q     <= 4'b0000;
            ie_q       <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pend_q     <= pend_d;
            ie_q       <= ie_d;
            armed_q    <= 1'b1;
        end
    end

    always_comb begin
        s_inc_o      = 1'b1;
        s_stack_o    = 1'b0;
        pushsignal_o = 1'b0;
        popsignal_o  = 1'b0;
        we3_o        = 1'b0;
        wez_o        = 1'b0;
        we4_o        = 1'b0;
        we_out_o     = 1'b0;
        s_inm_o      = 2'd0;
        s_in_o       = 2'd0;
        s_out_o      = 2'd0;
        op_alu_o     = 3'd0;
        irq_take_o   = 1'b0;
        irq_vector_o = 10'd0;
        irq_ack_o    = 4'b0000;
        if (take) begin
            // Suppressed instruction: the stacked PC makes it re-execute after RETI.
            pushsignal_o = 1'b1;
            irq_take_o   = 1'b1;
            irq_ack_o    = sel_oh;
            irq_vector_o = VEC_BASE + {6'd0, sel_idx, 2'b00};
        end else begin
            casez (opcode_i)
                6'b1?????: begin
                    we3_o    = 1'b1;
                    wez_o    = 1'b1;
                    op_alu_o = opcode_i[4:2];
                end
                6'b0001??: begin
                    we3_o   = 1'b1;
                    s_inm_o = 2'd1;
                end
                6'b0010??: begin
                    we3_o   = 1'b1;
                    s_inm_o = 2'd2;
                end
                6'b0011??: we4_o = 1'b1;
                6'b0100??: begin
                    we3_o   = 1'b1;
                    s_inm_o = 2'd3;
                    s_in_o  = opcode_i[1:0];
                end
                6'b0101??: we_out_o = 1'b1;
                6'b0110??: begin
                    we_out_o = 1'b1;
                    s_out_o  = 2'd1;
                end
                6'b011100: s_inc_o = 1'b0;
                6'b011101: s_inc_o = ~z_i;
                6'b011110: s_inc_o = z_i;
                6'b011111: begin
                    s_inc_o      = 1'b0;
                    pushsignal_o = 1'b1;
                end
                OP_RET, OP_RETI: begin
                    popsignal_o = 1'b1;
                    s_stack_o   = 1'b1;
                end
                default: ;
            endcase
        end
        if (!rst_ni) begin
            we3_o        = 1'b0;
            wez_o        = 1'b0;
            we4_o        = 1'b0;
            we_out_o     = 1'b0;
            pushsignal_o = 1'b0;
            popsignal_o  = 1'b0;
        end
    end

    assign ie_o = ie_q;

endmodule

// File: tb/tb_control_unit_irq.sv
// Directed bench for control_unit_irq: decode sweep plus interrupt scenarios.
module tb_control_unit_irq;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [5:0] opcode_i;
    logic       z_i;
    logic [3:0] irq_i;
    logic       s_inc_o, s_stack_o, pushsignal_o, popsignal_o;
    logic       we3_o, wez_o, we4_o, we_out_o;
    logic [1:0] s_inm_o, s_in_o, s_out_o;
    logic [2:0] op_alu_o;
    logic       irq_take_o;
    logic [9:0] irq_vector_o;
    logic [3:0] irq_ack_o;
    logic       ie_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] RETI = 6'b000010;
    localparam logic [5:0] EI   = 6'b000011;
    localparam logic [5:0] ADD  = 6'b100000;

    control_unit_irq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .opcode_i     (opcode_i),
        .z_i          (z_i),
        .irq_i        (irq_i),
        .s_inc_o      (s_inc_o),
        .s_stack_o    (s_stack_o),
        .pushsignal_o (pushsignal_o),
        .popsignal_o  (popsignal_o),
        .we3_o        (we3_o),
        .wez_o        (wez_o),
        .we4_o        (we4_o),
        .we_out_o     (we_out_o),
        .s_inm_o      (s_inm_o),
        .s_in_o       (s_in_o),
        .s_out_o      (s_out_o),
        .op_alu_o     (op_alu_o),
        .irq_take_o   (irq_take_o),
        .irq_vector_o (irq_vector_o),
        .irq_ack_o    (irq_ack_o),
        .ie_o         (ie_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni   = 1'b0;
        opcode_i = NOP;
        z_i      = 1'b0;
        irq_i    = 4'b0000;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Packed {s_inc,s_stack,push,pop,we3,wez,we4,we_out,s_inm,s_in,s_out,op_alu}
    function automatic logic [16:0] exp_dec(input logic [5:0] op, input logic z);
        logic s_inc = 1'b1, s_stack = 1'b0, push = 1'b0, pop = 1'b0;
        logic we3 = 1'b0, wez = 1'b0, we4 = 1'b0, we_out = 1'b0;
        logic [1:0] s_inm = 2'd0, s_in = 2'd0, s_out = 2'd0;
        logic [2:0] alu = 3'd0;
        if (op[5]) begin
            we3 = 1'b1; wez = 1'b1; alu = op[4:2];
        end else begin
            case (op[4:2])
                3'b001: begin we3 = 1'b1; s_inm = 2'd1; end
                3'b010: begin we3 = 1'b1; s_inm = 2'd2; end
                3'b011: we4 = 1'b1;
                3'b100: begin we3 = 1'b1; s_inm = 2'd3; s_in = op[1:0]; end
                3'b101: we_out = 1'b1;
                3'b110: begin we_out = 1'b1; s_out = 2'd1; end
                3'b111: begin
                    if (op[1:0] == 2'b00) s_inc = 1'b0;
                    if (op[1:0] == 2'b01) s_inc = !z;
                    if (op[1:0] == 2'b10) s_inc = z;
                    if (op[1:0] == 2'b11) begin s_inc = 1'b0; push = 1'b1; end
                end
                default: if (op[1:0] == 2'b01 || op[1:0] == 2'b10) begin
                    pop = 1'b1; s_stack = 1'b1;
                end
            endcase
        end
        return {s_inc, s_stack, push, pop, we3, wez, we4, we_out, s_inm, s_in, s_out, alu};
    endfunction

    function automatic logic [16:0] act_dec();
        return {s_inc_o, s_stack_o, pushsignal_o, popsignal_o, we3_o, wez_o, we4_o,
                we_out_o, s_inm_o, s_in_o, s_out_o, op_alu_o};
    endfunction

    initial begin
        rst_ni   = 1'b0;
        opcode_i = NOP;
        z_i      = 1'b0;
        irq_i    = 4'b0000;
        #2;
        check_eq("reset_ie", ie_o, 1'b0);
        check_eq("reset_take", irq_take_o, 1'b0);
        opcode_i = ADD;
        #1;
        check_eq("reset_we3_gated", we3_o, 1'b0);
        do_reset();

        // Decode sweep
        for (int op = 0; op < 64; op++) begin
            for (int zz = 0; zz < 2; zz++) begin
                opcode_i = op[5:0];
                z_i      = zz[0];
                #1;
                check_eq($sformatf("dec_op%02h_z%0d", op, zz), act_dec(), exp_dec(op[5:0], zz[0]));
                tick();
            end
        end
        opcode_i = 6'b101100; z_i = 1'b0; #1;
        check_eq("alu3_op", op_alu_o, 3'd3);
        check_eq("alu3_wez", wez_o, 1'b1);
        opcode_i = 6'b011101; z_i = 1'b1; #1;
        check_eq("jz_taken", s_inc_o, 1'b0);
        z_i = 1'b0;

        // Basic interrupt on line 2
        do_reset();
        opcode_i = EI; tick();
        check_eq("basic_ie_set", ie_o, 1'b1);
        opcode_i = ADD; irq_i = 4'b0100; #1;
        check_eq("basic_no_take_yet", irq_take_o, 1'b0);
        check_eq("basic_we3_before", we3_o, 1'b1);
        tick();
        check_eq("basic_take", irq_take_o, 1'b1);
        check_eq("basic_vector", irq_vector_o, 10'h3F8);
        check_eq("basic_ack", irq_ack_o, 4'b0100);
        check_eq("basic_push", pushsignal_o, 1'b1);
        check_eq("basic_we3_suppr", we3_o, 1'b0);
        check_eq("basic_wez_suppr", wez_o, 1'b0);
        tick();
        check_eq("basic_ie_clr", ie_o, 1'b0);
        check_eq("basic_pend_clr", dut.pend_q, 4'b0000);
        check_eq("basic_take_done", irq_take_o, 1'b0);
        check_eq("basic_we3_after", we3_o, 1'b1);

        // Priority: line 3 then line 1 while disabled
        do_reset();
        irq_i = 4'b1000; tick();
        irq_i = 4'b1010; tick();
        check_eq("prio_no_take_ie0", irq_take_o, 1'b0);
        opcode_i = EI; tick();
        opcode_i = NOP; #1;
        check_eq("prio_take1", irq_take_o, 1'b1);
        check_eq("prio_ack1", irq_ack_o, 4'b0010);
        check_eq("prio_vec1", irq_vector_o, 10'h3F4);
        tick();
        opcode_i = RETI; #1;
        check_eq("prio_reti_pop", popsignal_o, 1'b1);
        check_eq("prio_reti_stack", s_stack_o, 1'b1);
        check_eq("prio_reti_no_take", irq_take_o, 1'b0);
        tick();
        opcode_i = NOP; #1;
        check_eq("prio_take3", irq_take_o, 1'b1);
        check_eq("prio_ack3", irq_ack_o, 4'b1000);
        check_eq("prio_vec3", irq_vector_o, 10'h3FC);
        tick();

        // Level held high across RETI
        do_reset();
        opcode_i = EI; irq_i = 4'b0001; tick();
        opcode_i = NOP; #1;
        check_eq("level_take", irq_take_o, 1'b1);
        check_eq("level_vec0", irq_vector_o, 10'h3F0);
        tick();
        opcode_i = RETI; tick();
        opcode_i = NOP; #1;
        check_eq("level_no_retake", irq_take_o, 1'b0);
        tick();
        check_eq("level_no_retake2", irq_take_o, 1'b0);

        // Drop and re-raise during ISR
        irq_i = 4'b0000; tick();
        irq_i = 4'b0001; tick();
        check_eq("rerise_take", irq_take_o, 1'b1);
        tick();
        irq_i = 4'b0000; tick();
        irq_i = 4'b0001; tick();
        check_eq("rerise_held_ie0", irq_take_o, 1'b0);
        opcode_i = RETI; tick();
        opcode_i = NOP; #1;
        check_eq("rerise_take_again", irq_take_o, 1'b1);
        tick();
        opcode_i = RETI; tick();
        opcode_i = NOP; #1;
        check_eq("rerise_only_once", irq_take_o, 1'b0);

        // Set-wins collision on line 0
        do_reset();
        irq_i = 4'b0001; tick();
        irq_i = 4'b0000; opcode_i = EI; tick();
        opcode_i = NOP; #1;
        check_eq("setwin_take", irq_take_o, 1'b1);
        irq_i = 4'b0001; tick();
        check_eq("setwin_pend", dut.pend_q, 4'b0001);
        check_eq("setwin_ie0", ie_o, 1'b0);
        check_eq("setwin_no_take", irq_take_o, 1'b0);
        opcode_i = RETI; tick();
        opcode_i = NOP; #1;
        check_eq("setwin_retake", irq_take_o, 1'b1);
        check_eq("setwin_ack", irq_ack_o, 4'b0001);
        tick();

        // Reset mid-ISR with lines 1 and 3 pending
        do_reset();
        opcode_i = EI; irq_i = 4'b0001; tick();
        opcode_i = NOP; irq_i = 4'b1011; tick();
        check_eq("rst_pend_before", dut.pend_q, 4'b1010);
        opcode_i = ADD;
        rst_ni = 1'b0; #1;
        check_eq("rst_we3", we3_o, 1'b0);
        check_eq("rst_wez", wez_o, 1'b0);
        check_eq("rst_take", irq_take_o, 1'b0);
        check_eq("rst_push", pushsignal_o, 1'b0);
        check_eq("rst_pend", dut.pend_q, 4'b0000);
        check_eq("rst_ie", ie_o, 1'b0);
        tick(); tick();
        rst_ni = 1'b1;
        opcode_i = EI; tick();
        opcode_i = NOP; #1;
        check_eq("rst_rel_no_take", irq_take_o, 1'b0);
        tick();
        check_eq("rst_rel_no_take2", irq_take_o, 1'b0);
        irq_i = 4'b1001; tick();
        irq_i = 4'b1011; tick();
        check_eq("rst_fresh_take", irq_take_o, 1'b1);
        check_eq("rst_fresh_ack", irq_ack_o, 4'b0010);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit_irq.md
# control_unit_irq

Control unit for the single-cycle CPU datapath. It decodes the 6-bit opcode into every datapath select and write-enable, evaluates conditional jumps against the Z flag, and adds a 4-line prioritized interrupt controller. The interrupt controller injects an interrupt entry (push current PC, jump to vector) at an instruction boundary. It sits beside the datapath and drives all of its control inputs, plus two new ones: `irq_take` and `irq_vector`.

## Interface
- `VEC_BASE`, 10'h3F0: vector of line i is `VEC_BASE + 4*i`, computed modulo 2^10.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction bits [15:10] from program memory.
- `z`  in  1  registered zero flag from datapath.
- `irq`  in  4  interrupt requests, synchronous to `clk`, rising-edge sensitive; bit 0 has highest priority.
- `s_inc`  out  1  next-PC select: 1 = PC+1, 0 = instruction jump target.
- `s_stack`  out  1  1 = next PC comes from stack pop.
- `pushsignal`, `popsignal`  out  1 each  stack push / pop strobes.
- `we3`, `wez`, `we4`, `we_out`  out  1 each  register file, Z flag, data memory and output-port write enables.
- `s_inm`  out  2  register write-data select: 0 ALU, 1 immediate, 2 data memory, 3 input port.
- `s_in`  out  2  input-port select.
- `s_out`  out  2  output-data select: 0 register, 1 immediate.
- `op_alu`  out  3  ALU operation.
- `irq_take`  out  1  interrupt entry this cycle. Datapath loads `irq_vector` into PC and pushes the current PC (not PC+1).
- `irq_vector`  out  10  entry address.
- `irq_ack`  out  4  one-hot line being accepted; valid only with `irq_take`.
- `ie`  out  1  global interrupt enable (status).

## Operation
- Default for every output: `s_inc`=1; all other outputs 0.
- Decode table, by `opcode`:
  - `1xxxxx` ALU: `we3`=1, `wez`=1, `op_alu`=opcode[4:2], `s_inm`=0.
  - `0001xx` LI: `we3`, `s_inm`=1.
  - `0010xx` LDM: `we3`, `s_inm`=2.
  - `0011xx` STM: `we4`.
  - `0100xx` IN: `we3`, `s_inm`=3, `s_in`=opcode[1:0].
  - `0101xx` OUT reg: `we_out`, `s_out`=0.
  - `0110xx` OUT imm: `we_out`, `s_out`=1.
  - `011100` J: `s_inc`=0.
  - `011101` JZ: `s_inc`=!z.
  - `011110` JNZ: `s_inc`=z.
  - `011111` CALL: `s_inc`=0, `pushsignal`=1. The stack stores PC+1.
  - `000001` RET: `popsignal`, `s_stack`=1.
  - `000010` RETI: same as RET, plus `ie`<=1.
  - `000011` EI: `ie`<=1.
  - `000000` NOP: outputs stay at defaults.
- No DI instruction: `ie` is cleared only by reset and by interrupt entry.
- Edge detection: `irq_prev` register. `pend[i]` is set on `irq[i] & !irq_prev[i]`; a pending request is held until it is taken.
- Take condition: `take = ie & |pend`. The selected line is the lowest-index set bit of `pend`.
- On take, for that cycle:
  - The instruction is suppressed: `we3`, `wez`, `we4`, `we_out` and `popsignal` are forced to 0, and the ALU/jump decode is ignored.
  - `pushsignal`=1, `irq_take`=1, `irq_ack`=one-hot(i), `irq_vector`=VEC_BASE+4*i.
  - The suppressed instruction re-executes after RETI, because the stack holds its PC.
- Registered on the take edge: `pend[i]`<=0 and `ie`<=0.
- Simultaneous events:
  - A new edge on line i in the same cycle it is taken leaves `pend[i]`=1 (set wins).
  - An EI or RETI executing in a cycle cannot coincide with a take, because a take suppresses it.
- Z is not saved on entry; ISRs must not rely on the interrupted Z value.

## Timing
- The decode path is purely combinational from `opcode`, `z`, `pend` and `ie`: zero-cycle latency, and the single-cycle CPU property is preserved.
- `irq` rising edge sampled at clock edge n sets `pend` after edge n. The earliest `irq_take` is the cycle between edges n and n+1.
- EI or RETI in cycle k: `ie`=1 from edge k. A pending request can be taken in cycle k+1, so the instruction after EI executes only if nothing is pending.
- Reset (async, any time, including mid-ISR):
  - `pend`, `irq_prev` and `ie` go to 0 immediately.
  - While `reset` is low, every write enable, `pushsignal`, `popsignal` and `irq_take` is held at 0.
  - A request whose line is already high at reset release does not produce an edge until it drops and rises again.

## Test plan
- Decode sweep: apply all 64 opcodes with z=0 and z=1 -> every output matches the table. Examples: `101100` gives `op_alu`=3 and `we3`=`wez`=1; `011101` with z=1 gives `s_inc`=0.
- Basic interrupt: EI, then raise `irq[2]` -> next cycle `irq_take`=1, `irq_vector`=0x3F8, `irq_ack`=0100, `pushsignal`=1, `we3`=0; following cycle `ie`=0 and `pend`=0.
- Priority: with `ie`=0, raise `irq[3]` then `irq[1]`; execute EI -> first take on line 1 (vector 0x3F4). RETI, then the next take is line 3 (vector 0x3FC).
- Level held high: `irq[0]` stays high across RETI -> no second take.
- Drop and re-raise during ISR: `irq[0]` dropped and re-raised during the ISR -> one further take after RETI.
- Set-wins collision: new edge on line 0 in its take cycle -> `pend[0]`=1 after the edge; taken again after RETI.
- Reset mid-ISR: assert `reset` low with `pend`=1010 -> all enables 0 immediately, `pend`=0, `ie`=0. No take after release until a fresh edge after EI.
